// File: rtl/ctrl_pipe_chain_pkg.sv
// ctrl_pipe_pkg: shared definitions for the control-signal pipeline.
//   - Bit positions of the fixed-meaning fields inside the control bundle.
//     Bits above PAYLOAD_LSB are payload and are carried without gating.
//   - ARM condition-code encodings.
//   - cond_eval(): combinational condition check against an NZCV nibble.
package ctrl_pipe_pkg;

    localparam int PCS         = 0;
    localparam int REGW        = 1;
    localparam int MEMW        = 2;
    localparam int MEMTOREG    = 3;
    localparam int BRANCH      = 4;
    localparam int NOWRITE     = 5;
    localparam int FLAGW_LO    = 6;  // FlagW[0]: update C,V
    localparam int FLAGW_HI    = 7;  // FlagW[1]: update N,Z
    localparam int PAYLOAD_LSB = 8;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    // nzcv is {N, Z, C, V}. 0xF is treated like AL.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic pass;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            default: pass = 1'b1;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/ctrl_pipe_chain_if.sv
// ctrl_pipe_chain_if: signal bundle between the decoder / hazard unit and the
// control pipeline.
//   master: decoder + hazard unit (drives decode slot, ALU flags, stall/flush)
//   slave : ctrl_pipe_chain
// Handshake: valid_d qualifies the decode slot for the current cycle. There is
// no ready; back-pressure is expressed only through stall[], so the decoder
// must hold the slot itself while stall[0] is high.
interface ctrl_pipe_chain_if #(
    parameter int N_STAGES = 4,
    parameter int CTRL_W   = 12,
    parameter int CNT_W    = 16
);
    logic                       valid_d;
    logic [CTRL_W-1:0]          ctrl_d;
    logic [3:0]                 cond_d;
    logic [3:0]                 alu_flags_e;
    logic [N_STAGES-1:0]        stall;
    logic [N_STAGES-1:0]        flush;

    logic [N_STAGES-1:0]        stage_valid_o;
    logic [N_STAGES*CTRL_W-1:0] stage_ctrl_o;
    logic                       cond_ex_e;
    logic                       branch_taken_e;
    logic [3:0]                 flags_o;
    logic [CNT_W-1:0]           retired_o;
    logic [CNT_W-1:0]           condfail_o;

    modport master (
        output valid_d, ctrl_d, cond_d, alu_flags_e, stall, flush,
        input  stage_valid_o, stage_ctrl_o, cond_ex_e, branch_taken_e,
               flags_o, retired_o, condfail_o
    );

    modport slave (
        input  valid_d, ctrl_d, cond_d, alu_flags_e, stall, flush,
        output stage_valid_o, stage_ctrl_o, cond_ex_e, branch_taken_e,
               flags_o, retired_o, condfail_o
    );
endinterface

// File: rtl/ctrl_pipe_chain_stage.sv
// ctrl_pipe_stage: one pipeline slot register {valid, ctrl, cond}.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, clears the slot
//   clr_i  : load all-zero (bubble); wins over en_i
//   en_i   : load d_i; when low the slot holds
//   d_i    : next slot contents
//   q_o    : current slot contents
module ctrl_pipe_stage #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] slot_d, slot_q;

    always_comb begin
        slot_d = slot_q;
        if (clr_i) begin
            slot_d = '0;
        end else if (en_i) begin
            slot_d = d_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign q_o = slot_q;
endmodule

// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain: control-bundle pipeline from decode to writeback.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : ctrl_pipe_chain_if.slave
//             in : valid_d, ctrl_d, cond_d, alu_flags_e, stall[], flush[]
//             out: stage_valid_o, stage_ctrl_o, cond_ex_e, branch_taken_e,
//                  flags_o, retired_o, condfail_o
// Stage 0 is execute. The condition is evaluated there against the internal
// NZCV register; PCS/RegW/MemW are gated as the bundle moves into stage 1.
module ctrl_pipe_chain
    import ctrl_pipe_pkg::*;
#(
    parameter int N_STAGES = 4,
    parameter int CTRL_W   = 12,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    ctrl_pipe_chain_if.slave bus
);
    localparam int SLOT_W = 1 + CTRL_W + 4;

    logic [N_STAGES-1:0][SLOT_W-1:0] slot_d, slot_q;
    logic [N_STAGES-1:0]             clr, en;

    logic              s0_valid;
    logic [CTRL_W-1:0] s0_ctrl;
    logic [3:0]        s0_cond;
    logic [CTRL_W-1:0] s1_ctrl_d;
    logic              cond_ex;
    logic              leave_e;
    logic              retire;

    logic [3:0]        flags_d, flags_q;
    logic [CNT_W-1:0]  retired_d, retired_q;
    logic [CNT_W-1:0]  condfail_d, condfail_q;

    assign {s0_valid, s0_ctrl, s0_cond} = slot_q[0];

    // An invalid slot never "passes", so bubbles cannot gate-enable anything.
    assign cond_ex = s0_valid & cond_eval(s0_cond, flags_q);

    always_comb begin
        s1_ctrl_d           = s0_ctrl;
        s1_ctrl_d[PCS]      = s0_ctrl[PCS]  & cond_ex;
        s1_ctrl_d[REGW]     = s0_ctrl[REGW] & cond_ex & ~s0_ctrl[NOWRITE];
        s1_ctrl_d[MEMW]     = s0_ctrl[MEMW] & cond_ex;
    end

    for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign slot_d[k] = {bus.valid_d, bus.ctrl_d, bus.cond_d};
            assign clr[k]    = bus.flush[k];
        end else begin : g_body
            if (k == 1) begin : g_gate
                assign slot_d[k] = {s0_valid, s1_ctrl_d, s0_cond};
            end else begin : g_pass
                assign slot_d[k] = slot_q[k-1];
            end
            // A stalled upstream stage leaves nothing to hand on: insert a
            // bubble unless this stage is itself holding.
            assign clr[k] = bus.flush[k] | (bus.stall[k-1] & ~bus.stall[k]);
        end

        assign en[k] = ~bus.stall[k];

        ctrl_pipe_stage #(.W(SLOT_W)) u_stage (
            .clk   (clk),
            .rst_n (reset),
            .clr_i (clr[k]),
            .en_i  (en[k]),
            .d_i   (slot_d[k]),
            .q_o   (slot_q[k])
        );

        assign bus.stage_valid_o[k]                  = slot_q[k][SLOT_W-1];
        assign bus.stage_ctrl_o[k*CTRL_W +: CTRL_W]  = slot_q[k][4 +: CTRL_W];
    end

    // The cond field of the last stage has no consumer.
    logic unused_last_cond;
    assign unused_last_cond = ^slot_q[N_STAGES-1][3:0];

    // E instruction actually moves on (not held, not killed in stage 1):
    // the only edge at which it may touch flags or the fail counter.
    assign leave_e = s0_valid & ~bus.stall[0] & ~bus.flush[1];
    assign retire  = slot_q[N_STAGES-1][SLOT_W-1] & ~bus.stall[N_STAGES-1]
                   & ~bus.flush[N_STAGES-1];

    always_comb begin
        flags_d = flags_q;
        if (leave_e && cond_ex) begin
            if (s0_ctrl[FLAGW_HI]) flags_d[3:2] = bus.alu_flags_e[3:2];
            if (s0_ctrl[FLAGW_LO]) flags_d[1:0] = bus.alu_flags_e[1:0];
        end
    end

    // Counters saturate at all-ones.
    always_comb begin
        retired_d  = retired_q;
        condfail_d = condfail_q;
        if (retire && (retired_q != '1)) begin
            retired_d = retired_q + CNT_W'(1);
        end
        if (leave_e && !cond_ex && (condfail_q != '1)) begin
            condfail_d = condfail_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q    <= '0;
            retired_q  <= '0;
            condfail_q <= '0;
        end else begin
            flags_q    <= flags_d;
            retired_q  <= retired_d;
            condfail_q <= condfail_d;
        end
    end

    assign bus.cond_ex_e      = cond_ex;
    assign bus.branch_taken_e = cond_ex & s0_ctrl[BRANCH];
    assign bus.flags_o        = flags_q;
    assign bus.retired_o      = retired_q;
    assign bus.condfail_o     = condfail_q;
endmodule
